// File: rtl/stream_upsizer.sv
// -----------------------------------------------------------------------------
// stream_upsizer
//
// Valid/ready width upsizer. Packs RATIO consecutive IN_W-bit ingress beats
// into one IN_W*RATIO-bit egress word, little-endian (first beat in lane 0).
// A beat with i_last_i set closes the word early; e_keep_o then marks the
// populated lanes, which are always contiguous from lane 0, and unpopulated
// lanes are zero. Runs at one beat per cycle while egress is not stalled.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   i_valid_i  in   ingress beat valid
//   i_data_i   in   ingress beat data, IN_W bits
//   i_last_i   in   ingress beat closes the current word/packet
//   i_ready_o  out  ingress ready (combinational)
//   e_valid_o  out  egress word valid
//   e_data_o   out  egress word, lane k = [k*IN_W +: IN_W]
//   e_keep_o   out  egress lane-populated mask, RATIO bits
//   e_last_o   out  egress word was closed by i_last_i
//   e_ready_i  in   egress ready
// -----------------------------------------------------------------------------
module stream_upsizer #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid_i,
    input  logic [IN_W-1:0]       i_data_i,
    input  logic                  i_last_i,
    output logic                  i_ready_o,
    output logic                  e_valid_o,
    output logic [IN_W*RATIO-1:0] e_data_o,
    output logic [RATIO-1:0]      e_keep_o,
    output logic                  e_last_o,
    input  logic                  e_ready_i
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] acc_data;
    logic [RATIO-1:0] acc_keep;

    logic             completing;
    logic             out_free;
    logic             accept;
    logic [OUT_W-1:0] merged_data;
    logic [RATIO-1:0] merged_keep;

    // A beat only needs the output register if it finishes a word; every
    // other beat lands in the accumulator and can always be taken.
    assign completing = (count == LAST_IDX) | i_last_i;
    assign out_free   = ~e_valid_o | e_ready_i;
    assign i_ready_o  = rst_n & (~completing | out_free);
    assign accept     = i_valid_i & i_ready_o;

    // Accumulator with the presented beat inserted at the current lane.
    always_comb begin
        // NOTE: assign defaults first so every path drives every bit; a
        // combinational output left unassigned on some path infers a latch.
        merged_data = acc_data;
        merged_keep = acc_keep;
        merged_data[count*IN_W +: IN_W] = i_data_i;
        merged_keep[count]              = 1'b1;
    end

    // Accumulator and lane counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments in clocked blocks, so every
            // register samples the pre-edge values regardless of order.
            count    <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (accept) begin
            if (completing) begin
                // Word leaves for the output register; start a fresh one so
                // unpopulated lanes of the next word read as zero.
                count    <= '0;
                acc_data <= '0;
                acc_keep <= '0;
            end else begin
                count    <= count + CNT_W'(1);
                acc_data <= merged_data;
                acc_keep <= merged_keep;
            end
        end
    end

    // Output register. A completing beat is only accepted when the register
    // is free, so loading a new word and draining the old one can share an
    // edge without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_o <= 1'b0;
            e_data_o  <= '0;
            e_keep_o  <= '0;
            e_last_o  <= 1'b0;
        end else if (accept && completing) begin
            e_valid_o <= 1'b1;
            e_data_o  <= merged_data;
            e_keep_o  <= merged_keep;
            e_last_o  <= i_last_i;
        end else if (e_valid_o && e_ready_i) begin
            e_valid_o <= 1'b0;
        end
    end

endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Valid/ready width upsizer that sits directly downstream of skid_buffer on its egress stream.
- Packs RATIO consecutive IN_W-bit beats into one IN_W*RATIO-bit word, little-endian: the first beat goes to lane 0.
- An optional i_last_i flushes a partial word early, with per-lane keep bits marking the populated lanes.
- Sustains one input beat per cycle with no bubbles while the output is not back-pressured.

Parameters:
- IN_W, 8, width of one input beat in bits.
- RATIO, 4, input beats per output word; must be ≥2. Count width is $clog2(RATIO).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_valid_i  input  1  ingress beat valid.
- i_data_i  input  IN_W  ingress beat data.
- i_last_i  input  1  ingress beat closes the current word/packet.
- i_ready_o  output  1  ingress ready.
- e_valid_o  output  1  egress word valid.
- e_data_o  output  IN_W*RATIO  egress word; lane k = bits [k*IN_W +: IN_W].
- e_keep_o  output  RATIO  egress lane-populated mask.
- e_last_o  output  1  egress word closed by i_last_i.
- e_ready_i  input  1  egress ready.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous):
  - e_valid_o=0, e_data_o=0, e_keep_o=0, e_last_o=0.
  - Lane count=0; accumulator and its keep mask cleared.
  - i_ready_o forced to 0 while rst_n is low.
  - Reset mid-word discards any partial accumulation and any pending output word.
- Handshakes:
  - Ingress transfer when i_valid_i & i_ready_o at the clk edge.
  - Egress transfer when e_valid_o & e_ready_i at the clk edge.
- Completing beat: an accepted beat with count==RATIO-1 or i_last_i=1.
- i_ready_o (combinational, no registered ready path):
  - 1 when the presented beat is not completing.
  - Otherwise 1 only when the output register is free: !e_valid_o | e_ready_i.
- Accepted non-completing beat: lane[count] <= i_data_i; keep[count] <= 1; count <= count+1.
- Accepted completing beat, single edge:
  - e_data_o <= accumulator with lane[count] = i_data_i.
  - e_keep_o <= keep with bit[count] set; e_last_o <= i_last_i; e_valid_o <= 1.
  - count <= 0; accumulator and keep cleared.
- Partial words:
  - Unpopulated lanes are 0 and their keep bits are 0.
  - Keep is always contiguous from lane 0.
- Latency: a word is valid on e_* the cycle after its completing beat is accepted.
- Egress draining: e_valid_o & e_ready_i with no new completing beat gives e_valid_o <= 0. Data, keep and last may hold stale values, but the bench checks them only while valid.
- Stability: while e_valid_o & !e_ready_i, e_data_o, e_keep_o and e_last_o hold exactly.
- Simultaneous events: egress drain and a completing beat in the same cycle leave e_valid_o at 1 with the new word loaded (no bubble).
- Back-pressure: with egress stalled, up to RATIO-1 further beats are accepted into the accumulator. The completing beat then stalls (i_ready_o=0) until egress drains.
- i_last_i on the first beat (count=0) gives a single-lane word, e_keep_o=0b0001, e_last_o=1.
- Count wrap: count returns to 0 after each completing beat and never exceeds RATIO-1.
- i_valid_i=0: no state change other than egress drain. i_data_i and i_last_i are ignored.

Test Plan:
- Reset, then beats 0x11,0x22,0x33,0x44 back-to-back with e_ready_i=1 -> one cycle after 0x44: e_data_o=0x44332211, e_keep_o=0xF, e_last_o=0, e_valid_o for 1 cycle.
- 8 continuous beats 0x01..0x08, e_ready_i=1 -> i_ready_o never drops; words 0x04030201 then 0x08070605 on consecutive-word cycles.
- Beats 0xAA,0xBB with i_last_i on 0xBB -> e_data_o=0x0000BBAA, e_keep_o=0x3, e_last_o=1. Then a single beat 0xCC with i_last_i -> 0x000000CC, keep=0x1, last=1.
- e_ready_i=0, stream 0x10..0x17 -> first word 0x13121110 held stable; 0x14..0x16 accepted; i_ready_o=0 on 0x17 until e_ready_i=1. Then 0x17161514 follows with no lost or duplicated beat.
- Drain and completion in the same cycle: e_ready_i=1 on the cycle 4th beat 0x24 is accepted while the previous word is valid -> e_valid_o stays 1, e_data_o=0x24232221.
- Assert rst_n=0 asynchronously (between edges) after 2 beats and while a word is pending -> e_valid_o=0 immediately, i_ready_o=0. After release, beats 0x55..0x58 give exactly 0x58575655, keep 0xF.
